// File: rtl/gun_input_port.sv
// Light-gun input port: 4 ms sample strobe, gun position/button capture with
// debounce, and a small read-only register window for the CPU input path.
module gun_input_port #(
  parameter int unsigned TICK_DIV = 48000,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic       clock_12,
  input  logic       reset,
  input  logic [5:0] gun_h,
  input  logic [5:0] gun_v,
  input  logic       btn_trigger,
  input  logic       btn_grenade,
  output logic       cnt_4ms_o,
  input  logic       cpu_rd,
  input  logic [1:0] cpu_addr,
  output logic [7:0] cpu_dout
);

  localparam logic [15:0] LAST    = 16'(TICK_DIV - 1);
  localparam logic [15:0] HALF    = 16'(TICK_DIV / 2);
  localparam logic [3:0]  DB_MASK = 4'((1 << DEBOUNCE) - 1);

  logic [15:0] count;
  logic [15:0] count_next;
  logic        tick;
  logic        cnt_4ms_q;

  logic [5:0]  sample_h;
  logic [5:0]  sample_v;
  logic [5:0]  shadow_v;
  logic [7:0]  seq;
  logic        new_flag;

  logic [1:0]  btn_raw;
  logic [3:0]  hist      [2];
  logic [3:0]  hist_next [2];
  logic [1:0]  btn_db;
  logic [1:0]  btn_db_next;

  logic        rd_h;
  logic        rd_flag;

  assign tick      = (count == LAST);
  assign btn_raw   = {btn_grenade, btn_trigger};
  assign rd_h      = cpu_rd && (cpu_addr == 2'd0);
  assign rd_flag   = cpu_rd && (cpu_addr == 2'd2);
  assign cnt_4ms_o = cnt_4ms_q;

  always_comb begin
    count_next = count + 16'd1;
    if (tick) count_next = '0;
  end

  // Square wave is registered from the next count so it is glitch-free and
  // still high exactly while count >= TICK_DIV/2.
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      count     <= '0;
      cnt_4ms_q <= 1'b0;
    end else begin
      count     <= count_next;
      cnt_4ms_q <= (count_next >= HALF);
    end
  end

  // The window covers the last DEBOUNCE samples including the one taken now.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      hist_next[i]   = {hist[i][2:0], btn_raw[i]};
      btn_db_next[i] = btn_db[i];
      if (((hist_next[i] & DB_MASK) == DB_MASK) && !btn_db[i])
        btn_db_next[i] = 1'b1;
      else if (((hist_next[i] & DB_MASK) == 4'd0) && btn_db[i])
        btn_db_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      sample_h <= '0;
      sample_v <= '0;
      seq      <= '0;
      hist[0]  <= '0;
      hist[1]  <= '0;
      btn_db   <= '0;
    end else if (tick) begin
      sample_h <= gun_h;
      sample_v <= gun_v;
      seq      <= seq + 8'd1;
      hist[0]  <= hist_next[0];
      hist[1]  <= hist_next[1];
      btn_db   <= btn_db_next;
    end
  end

  // A tick in the same cycle as an addr-2 read keeps the flag set.
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset)        new_flag <= 1'b0;
    else if (tick)    new_flag <= 1'b1;
    else if (rd_flag) new_flag <= 1'b0;
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset)     shadow_v <= '0;
    else if (rd_h) shadow_v <= sample_v;
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      cpu_dout <= '0;
    end else if (cpu_rd) begin
      unique case (cpu_addr)
        2'd0: cpu_dout <= {2'b00, sample_h};
        2'd1: cpu_dout <= {2'b00, shadow_v};
        2'd2: cpu_dout <= {new_flag, 5'b0, btn_db[1], btn_db[0]};
        2'd3: cpu_dout <= seq;
      endcase
    end
  end

endmodule

// File: tb/tb_gun_input_port.sv
// Directed bench for gun_input_port with TICK_DIV=8, DEBOUNCE=2.
module tb_gun_input_port;

  logic       clock_12 = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] gun_h = '0;
  logic [5:0] gun_v = '0;
  logic       btn_trigger = 1'b0;
  logic       btn_grenade = 1'b0;
  logic       cnt_4ms_o;
  logic       cpu_rd = 1'b0;
  logic [1:0] cpu_addr = '0;
  logic [7:0] cpu_dout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  gun_input_port #(.TICK_DIV(8), .DEBOUNCE(2)) dut (
    .clock_12    (clock_12),
    .reset       (reset),
    .gun_h       (gun_h),
    .gun_v       (gun_v),
    .btn_trigger (btn_trigger),
    .btn_grenade (btn_grenade),
    .cnt_4ms_o   (cnt_4ms_o),
    .cpu_rd      (cpu_rd),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout)
  );

  always #5 clock_12 = ~clock_12;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  // One cycle: count during cycle c (after reset release) is c mod 8.
  task automatic next_cyc();
    @(negedge clock_12);
    cyc++;
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) next_cyc();
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    cpu_rd   = 1'b1;
    cpu_addr = a;
    next_cyc();
    cpu_rd   = 1'b0;
    check(tag, cpu_dout, exp);
  endtask

  initial begin
    gun_h = 6'd21;
    gun_v = 6'd42;
    repeat (3) @(negedge clock_12);
    check("rst_cnt4ms", {7'd0, cnt_4ms_o}, 8'h00);
    check("rst_dout", cpu_dout, 8'h00);
    reset = 1'b0;
    cyc = 0;

    // square wave, first tick at cycle 7
    while (cyc < 8) begin
      check($sformatf("sq_c%0d", cyc), {7'd0, cnt_4ms_o}, (cyc % 8 >= 4) ? 8'h01 : 8'h00);
      next_cyc();
    end
    rd_check("first_flag", 2'd2, 8'h80);
    rd_check("pair_h", 2'd0, 8'h15);
    gun_h = 6'd5;
    gun_v = 6'd9;
    while (cyc < 16) begin
      check($sformatf("sq_c%0d", cyc), {7'd0, cnt_4ms_o}, (cyc % 8 >= 4) ? 8'h01 : 8'h00);
      next_cyc();
    end
    rd_check("pair_v", 2'd1, 8'h2A);
    rd_check("h_tick2", 2'd0, 8'h05);
    rd_check("v_tick2", 2'd1, 8'h09);
    rd_check("seq_2", 2'd3, 8'h02);
    next_cyc();
    check("dout_hold", cpu_dout, 8'h02);

    // one-tick trigger pulse must be rejected
    btn_trigger = 1'b1;
    goto_cyc(24);
    btn_trigger = 1'b0;
    rd_check("db_glitch1", 2'd2, 8'h80);
    goto_cyc(32);
    rd_check("db_glitch2", 2'd2, 8'h80);
    btn_trigger = 1'b1;
    goto_cyc(40);
    rd_check("db_trig_1tick", 2'd2, 8'h80);
    goto_cyc(48);
    rd_check("db_trig_on", 2'd2, 8'h81);
    btn_grenade = 1'b1;
    goto_cyc(56);
    rd_check("db_gren_1tick", 2'd2, 8'h81);
    goto_cyc(64);
    rd_check("db_gren_on", 2'd2, 8'h83);
    btn_trigger = 1'b0;
    btn_grenade = 1'b0;
    goto_cyc(72);
    rd_check("db_off_1tick", 2'd2, 8'h83);
    goto_cyc(80);
    rd_check("db_off", 2'd2, 8'h80);

    // flag race: read in the tick cycle
    goto_cyc(87);
    rd_check("race_flag_old", 2'd2, 8'h00);
    rd_check("race_flag_set", 2'd2, 8'h80);

    // pair race: addr-0 read in the tick cycle
    gun_h = 6'd63;
    gun_v = 6'd33;
    goto_cyc(95);
    rd_check("race_h_old", 2'd0, 8'h05);
    rd_check("race_v_old", 2'd1, 8'h09);
    rd_check("race_h_new", 2'd0, 8'h3F);
    rd_check("race_v_new", 2'd1, 8'h21);
    rd_check("seq_12", 2'd3, 8'h0C);

    // sequence wrap after 256 ticks
    goto_cyc(2048);
    rd_check("seq_wrap", 2'd3, 8'h00);
    goto_cyc(2056);
    rd_check("seq_after_wrap", 2'd3, 8'h01);

    // async reset at count 5
    goto_cyc(2060);
    rd_check("pre_rst_h", 2'd0, 8'h3F);
    check("pre_rst_cnt4ms", {7'd0, cnt_4ms_o}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("async_cnt4ms", {7'd0, cnt_4ms_o}, 8'h00);
    check("async_dout", cpu_dout, 8'h00);
    next_cyc();
    next_cyc();
    reset = 1'b0;
    cyc = 0;
    rd_check("post_rst_h", 2'd0, 8'h00);
    rd_check("post_rst_v", 2'd1, 8'h00);
    rd_check("post_rst_flag", 2'd2, 8'h00);
    rd_check("post_rst_seq", 2'd3, 8'h00);
    goto_cyc(7);
    check("post_rst_c7", {7'd0, cnt_4ms_o}, 8'h01);
    next_cyc();
    check("post_rst_c8", {7'd0, cnt_4ms_o}, 8'h00);
    rd_check("post_rst_tick", 2'd3, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gun_input_port.md
# gun_input_port

Game-side receiver for the light-gun position and button interface. It generates the 4 ms sample strobe that the top level uses to step its joystick-driven gun accumulator. On each strobe it captures that 6-bit horizontal/vertical gun position and the trigger/grenade buttons, debounces the buttons, and presents coherent register reads to the williams2 CPU input path.

## Interface
Parameters:
- TICK_DIV, 48000: clock_12 cycles per sample period (4 ms at 12 MHz); legal range 4..65535, even.
- DEBOUNCE, 2: consecutive agreeing samples required to change a debounced button; legal range 1..4.

Ports:
- clock_12  in  1  system clock, 12 MHz.
- reset  in  1  asynchronous, active-high reset.
- gun_h  in  6  gun horizontal position from the top-level accumulator, 0..63.
- gun_v  in  6  gun vertical position, 0..63.
- btn_trigger  in  1  raw trigger, active high.
- btn_grenade  in  1  raw grenade button, active high.
- cnt_4ms_o  out  1  sample square wave; its rising edge is the top-level gun-update event.
- cpu_rd  in  1  one-cycle read strobe.
- cpu_addr  in  2  register select.
- cpu_dout  out  8  registered read data.

## Operation
- Tick counter, 16 bits:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - cnt_4ms_o = 1 while count >= TICK_DIV/2, otherwise 0.
  - Internal tick pulse = 1 for the single cycle where count == TICK_DIV-1.
- Sampling, on tick:
  - sample_h <= gun_h; sample_v <= gun_v.
  - seq <= seq+1, 8-bit, wraps 255->0.
  - new_flag <= 1.
  - Trigger and grenade raw levels shift into per-button history registers.
  - The top level updates gun_h/gun_v on the cnt_4ms_o rising edge, TICK_DIV/2 cycles before the tick, so captured values are stable.
- Debounce, per button:
  - Debounced level changes on a tick only when the last DEBOUNCE samples, including the current one, all equal the new level and differ from the current debounced level.
  - Otherwise the level holds.
- Register map (read only; cpu_rd with any address is side-effect free except as listed):
  - addr 0: {2'b00, sample_h}. Side effect: shadow_v <= sample_v, so the next addr-1 read returns the V value paired with this H value.
  - addr 1: {2'b00, shadow_v}. shadow_v is not updated by ticks; a read without a preceding addr-0 read returns the last shadowed value.
  - addr 2: {new_flag, 5'b0, grenade_db, trigger_db}. Side effect: new_flag cleared.
  - addr 3: seq.
- Simultaneous events:
  - tick and addr-2 read in the same cycle: the read returns the pre-tick new_flag; set wins, so new_flag = 1 afterwards.
  - tick and addr-0 read in the same cycle: the read returns the old sample_h, and shadow_v takes the old sample_v, keeping the pair coherent.
- Reset, at any time including mid-period:
  - count, sample_h, sample_v, shadow_v, seq, new_flag, histories, debounced levels, cpu_dout and cnt_4ms_o all go to 0 immediately.
  - Counting resumes from 0 on the first clock after release.

## Timing
- cpu_dout is registered: data for a read in cycle N is valid from cycle N+1 and held until the next cpu_rd.
- Register side effects (shadow_v load, new_flag clear) take effect at the end of cycle N.
- First tick after reset release is at cycle TICK_DIV-1. First cnt_4ms_o rising edge is at count TICK_DIV/2.
- Tick period is exactly TICK_DIV cycles; cnt_4ms_o duty is exactly 50%.
- Button latency from a stable raw change to the debounced output is DEBOUNCE ticks at most, counted from the first tick that sees the new level.
- No combinational path from any input to any output.

## Test plan
- Tick generation with TICK_DIV=8:
  - Release reset, count clocks.
  - Required: cnt_4ms_o low for 4 cycles, then high for 4, repeating.
  - Required: the first tick sets new_flag at cycle 7; an addr-2 read then returns 0x80.
- Coherent pair:
  - gun_h=21 and gun_v=42 at tick 1; change to h=5, v=9 before tick 2.
  - Read addr 0 after tick 1, then read addr 1 after tick 2.
  - Required: reads return 0x15, then 0x2A.
- Debounce with DEBOUNCE=2:
  - Trigger high for 1 tick, then low: trigger_db stays 0.
  - Trigger high for 2 ticks: trigger_db goes to 1 at the second tick, and an addr-2 read returns 0x81.
- Flag race:
  - Issue an addr-2 read in the tick cycle.
  - Required: returned bit7 reflects the prior value; a following addr-2 read returns bit7=1.
- Sequence wrap:
  - Run 256 ticks.
  - Required: addr 3 reads 0x00; after one more tick it reads 0x01.
- Async reset mid-period:
  - Assert reset at count 5 with cnt_4ms_o=1 and sample_h=63.
  - Required: all outputs 0 in the same cycle; an addr-0 read after release returns 0x00.
